// File: rtl/apb_ctrl_pkg.sv
// Shared types and address-map constants for the APB master controller.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        ERR    = 2'b11
    } apb_state_t;

    // Values of addr[7:6] that select each slave; addr[7] set means unmapped.
    localparam logic [1:0] SLV1_SEL     = 2'b00;
    localparam logic [1:0] SLV2_SEL     = 2'b01;
    localparam int         UNMAPPED_BIT = 7;

    // Width of a counter that must be able to hold the value t.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_master_ctrl_decode.sv
// Combinational address decode: one-hot slave select plus unmapped flag.
// Only the two top address bits take part in the map, so only they come in.
module apb_addr_decode
    import apb_ctrl_pkg::*;
(
    input  logic [1:0] addr_top,
    output logic [1:0] sel,
    output logic       unmapped
);

    // sel[0] = slave1, sel[1] = slave2; nothing selected when unmapped.
    always_comb begin
        sel      = 2'b00;
        unmapped = 1'b0;
        case (addr_top)
            SLV1_SEL: sel      = 2'b01;
            SLV2_SEL: sel      = 2'b10;
            default:  unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: sequences one host request at a time onto a two-slave APB bus.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | req_ready high, bus idle, waiting for a host handshake
//   SETUP  | PSELx high, PENABLE low, exactly one cycle
//   ACCESS | PSELx and PENABLE high until PREADY or the wait budget runs out
//   ERR    | unmapped address, one cycle, no select, error response follows
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    apb_state_t        state_q;
    apb_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        sel_q;
    logic [1:0]        dec_sel;
    logic              dec_unmapped;
    logic              bus_active;
    logic              done_ok;
    logic              done_err;
    logic              handshake;
    logic [DATA_W-1:0] rd_mux;

    apb_addr_decode u_decode (
        .addr_top (req_addr[UNMAPPED_BIT -: 2]),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and bus-phase controls.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        PENABLE    = 1'b0;
        bus_active = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    handshake = 1'b1;
                    state_d   = dec_unmapped ? ERR : SETUP;
                end
            end
            SETUP: begin
                bus_active = 1'b1;
                state_d    = ACCESS;
            end
            ACCESS: begin
                bus_active = 1'b1;
                PENABLE    = 1'b1;
                if (PREADY) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    done_err = 1'b1;
                    state_d  = IDLE;
                end
            end
            ERR: begin
                done_err = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Selects follow the decode captured at handshake, only during SETUP/ACCESS.
    assign PSEL1 = bus_active & sel_q[0];
    assign PSEL2 = bus_active & sel_q[1];

    // ACCESS-cycle counter: cleared going into SETUP, saturates instead of wrapping.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else if (state_d == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Request capture; these hold through the transfer and afterwards in IDLE.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            sel_q  <= 2'b00;
        end else if (handshake) begin
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PWRITE <= req_write;
            sel_q  <= dec_sel;
        end
    end

    // Read data comes from whichever slave was selected.
    always_comb begin
        rd_mux = sel_q[1] ? PRDATA2 : PRDATA1;
    end

    // Response: single-cycle valid pulse; data and error hold until the next one.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (done_ok) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= PWRITE ? '0 : rd_mux;
            end else if (done_err) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule
